// File: rtl/dsp_logic_simd_v4.sv
// Lane-wise SIMD logic/arithmetic unit with a running XOR accumulator,
// behind an elastic valid/ready pipeline of STAGES registered slots.

module dsp_logic_simd_v4_lane #(
  parameter int WIDTH = 12
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'd0: y = a ^ b;
      3'd1: y = a & b;
      3'd2: y = a | b;
      3'd3: y = ~(a ^ b);
      3'd4: y = a + b;
      3'd5: y = a - b;
      3'd6: y = acc ^ a ^ b;
      default: y = '0;
    endcase
  end
endmodule

module dsp_logic_simd_v4 #(
  parameter int WIDTH  = 12,
  parameter int LANES  = 3,
  parameter int STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic                   in_last,
  input  logic [WIDTH*LANES-1:0] in_a,
  input  logic [WIDTH*LANES-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_y,
  output logic                   out_last
);
  localparam int VW = WIDTH * LANES;

  if (WIDTH < 1 || WIDTH > 48 || LANES < 1 || LANES > 4 || VW > 48 ||
      STAGES < 1 || STAGES > 3) begin : g_param_err
    $error("dsp_logic_simd_v4: illegal parameters WIDTH=%0d LANES=%0d STAGES=%0d",
           WIDTH, LANES, STAGES);
  end

  logic [LANES-1:0][WIDTH-1:0] a_l, b_l, acc, res;
  logic [STAGES-1:0]           vld_pipe, en;
  logic [STAGES-1:0][VW-1:0]   y_pipe;
  logic [STAGES-1:0]           last_pipe;
  logic                        accept;

  assign a_l = in_a;
  assign b_l = in_b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dsp_logic_simd_v4_lane #(.WIDTH(WIDTH)) u_lane (
      .op  (in_op),
      .a   (a_l[k]),
      .b   (b_l[k]),
      .acc (acc[k]),
      .y   (res[k])
    );
  end

  // A slot may load when out_ready is high or any slot from it to the
  // output is empty; this is the chained advance rule in closed form.
  always_comb begin
    logic hole;
    hole = 1'b0;
    en   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole  = hole | ~vld_pipe[i];
      en[i] = out_ready | hole;
    end
  end

  assign in_ready = en[0];
  assign accept   = in_valid & en[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      y_pipe    <= '0;
      last_pipe <= '0;
      acc       <= '0;
    end else begin
      if (en[0]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          y_pipe[0]    <= res;
          last_pipe[0] <= in_last;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          vld_pipe[i] <= vld_pipe[i-1];
          if (vld_pipe[i-1]) begin
            y_pipe[i]    <= y_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
          end
        end
      end
      // The op-6 lane result already is acc^a^b, so it doubles as next acc.
      if (accept && in_op == 3'd6)
        acc <= in_last ? '0 : res;
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out_y     = y_pipe[STAGES-1];
  assign out_last  = last_pipe[STAGES-1];
endmodule

// File: doc/dsp_logic_simd_v4.md
Name: dsp_logic_simd_v4

Overview:
- Parametrised successor to the fixed three-lane 12-bit SIMD XOR primitive.
- Performs a lane-wise logic or arithmetic op on packed operands over LANES independent lanes of WIDTH bits each.
- Op is selectable per beat; one op is a running XOR accumulator.
- Elastic valid/ready pipeline of configurable depth. Sits between Reticle-generated datapath stages wherever DSP-style SIMD logic is mapped.

Parameters:
- width, 12, bits per lane; 1..48.
- lanes, 3, number of lanes; 1..4; width*lanes must be <= 48.
- stages, 2, pipeline depth (beat latency in cycles); 1..3.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_op  in  3  operation select for this beat.
- in_last  in  1  final beat of an accumulate group (op 6 only).
- in_a  in  width*lanes  operand A; lane k = bits [k*width +: width].
- in_b  in  width*lanes  operand B; same packing as in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  width*lanes  packed result, same packing as in_a.
- out_last  out  1  in_last carried with the beat.

Behaviour:
- Reset: while reset=0, immediately clear all stage valid bits, the accumulator, out_y, out_last and out_valid to 0. in_ready=1 from the first edge after release. Asserting reset mid-stream drops all in-flight beats; nothing is emitted for them.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_valid, in_op, in_a, in_b and in_last are sampled only on acceptance.
  - out_y and out_last hold stable while out_valid && !out_ready.
- Pipeline:
  - stages registered slots, each with a valid bit.
  - A slot advances when the next slot is empty or advancing; the last slot advances when out_ready=1.
  - in_ready = !slot0_valid || slot0_advances. This is combinational from out_ready through the chain; there is no bubble.
  - Full throughput is 1 beat/cycle with out_ready held 1.
  - Latency: a beat accepted at edge N has out_valid=1 after edge N+stages-1 (stages=1 gives the result visible in the cycle after acceptance).
  - When the pipeline is full and out_ready=0, in_ready=0 and no beat is lost.
- Operation is computed at slot 0 and later slots only carry the result. Per lane k, with a = a_k and b = b_k:
  - 0 XOR: a^b.
  - 1 AND: a&b.
  - 2 OR: a|b.
  - 3 XNOR: ~(a^b).
  - 4 ADD: a+b mod 2^width. No carry crosses a lane boundary.
  - 5 SUB: a-b mod 2^width. No borrow crosses a lane boundary.
  - 6 XACC: acc_k <= acc_k ^ a ^ b. The result is the updated value acc_k^a^b. If in_last=1, the result is the same but acc_k <= 0 after that beat.
  - 7: result all zeros; the accumulator is unaffected.
- Accumulator:
  - width*lanes bits.
  - Updates only on an accepted op-6 beat.
  - Interleaved non-6 beats leave it untouched.
  - There is no wrap or overflow; it is pure XOR.
- out_last equals the accepted in_last for every op, not only op 6.
- Simultaneous accept and consume in the same cycle with a full pipeline is legal and keeps occupancy constant.
- Illegal parameter combinations (width*lanes > 48, lanes outside 1..4, stages outside 1..3) fail elaboration with an $error naming dsp_logic_simd_v4.

Test Plan:
- Reset and default params:
  - Stimulus: hold reset=0 with in_valid=1, then release.
  - Response: out_valid=0 and out_y=0 throughout reset; in_ready=1 after release.
- Lane isolation (width=12, lanes=3, op 4):
  - Stimulus: in_a=lanes{0xFFF,0x001,0x800}, in_b=lanes{0x001,0xFFF,0x800}.
  - Response: out_y=lanes{0x000,0x000,0x000}, with no carry into adjacent lanes. Repeat with op 5, a=0x000, b=0x001: result 0xFFF per lane.
- Logic ops:
  - Stimulus: a=0x0F0 and b=0x0FF per lane with ops 0,1,2,3,7.
  - Response: 0x00F, 0x0F0, 0x0FF, 0xFF0, 0x000 in order, each after exactly stages cycles.
- Accumulate:
  - Stimulus: op 6, lane0 beats (a,b) = (0x001,0), (0x002,0), (0x004,0) with in_last on the third, then (0x008,0).
  - Response: lane0 outputs 0x001, 0x003, 0x007, then 0x008 (the accumulator restarts after the last beat).
- Backpressure (stages=3):
  - Stimulus: stream 10 beats with out_ready toggling 1,0,0,1,…
  - Response: results are in order, none dropped or duplicated; in_ready=0 only while 3 slots are held; out_y is stable during stalls.
- Mid-stream reset:
  - Stimulus: 2 beats in flight plus an accumulator value of 0x5A; pulse reset=0 asynchronously between edges.
  - Response: out_valid drops immediately; no stale beat is emitted afterwards; the next op-6 beat with a=0x001 yields 0x001.
